// File: rtl/rop_csr_bank.sv
// rop_csr_bank -- double-buffered, multi-context ROP control-register bank.
//
// Each of NUM_CTX contexts holds a shadow register set, written through the
// CSR path, and an active set, read by the ROP pipeline. A commit copies
// shadow to active once that context has no fragments in flight.
//
// Optional build macro: ROP_CSR_READBACK_EN
//   defined   : csr_rd_* returns the shadow word, registered.
//   undefined : csr_rd_data is tied to 0.
//
// Ports
//   clk, reset                  clock; asynchronous active-low reset
//   csr_wr_*                    shadow write (valid/ready, ctx, addr 0..15, data)
//   commit_*                    commit request (valid/ready, ctx)
//   commit_done/_ctx            one-cycle pulse when an active copy is updated
//   frag_in/_ctx, frag_in_ready fragment entering the pipeline
//   frag_out/_ctx               fragment retiring
//   sel_ctx, csrs_out           registered active state of sel_ctx
//   csr_rd_*                    shadow readback (registered)
//
// csrs_out bit layout, MSB first:
//   zbuf_addr[200:169] zbuf_pitch[168:137] cbuf_addr[136:105] cbuf_pitch[104:73]
//   sfunc[72:70] zfunc[69:67] sfail[66:64] zpass[63:61] zfail[60:58]
//   blend_mode_a[57:55] blend_mode_rgb[54:52]
//   dst_a[51:48] dst_rgb[47:44] src_a[43:40] src_rgb[39:36]
//   blend_const[35:4] logic_op[3:0]
module rop_csr_bank #(
  parameter int NUM_CTX  = 4,
  parameter int CTX_BITS = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  parameter int CNT_BITS = 8,
  localparam int CSR_W   = 201
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                csr_wr_valid,
  output logic                csr_wr_ready,
  input  logic [CTX_BITS-1:0] csr_wr_ctx,
  input  logic [3:0]          csr_wr_addr,
  input  logic [31:0]         csr_wr_data,
  input  logic                commit_valid,
  output logic                commit_ready,
  input  logic [CTX_BITS-1:0] commit_ctx,
  output logic                commit_done,
  output logic [CTX_BITS-1:0] commit_done_ctx,
  input  logic                frag_in,
  output logic                frag_in_ready,
  input  logic [CTX_BITS-1:0] frag_ctx,
  input  logic                frag_out,
  input  logic [CTX_BITS-1:0] frag_out_ctx,
  input  logic [CTX_BITS-1:0] sel_ctx,
  output logic [CSR_W-1:0]    csrs_out,
  input  logic                csr_rd_valid,
  input  logic [CTX_BITS-1:0] csr_rd_ctx,
  input  logic [3:0]          csr_rd_addr,
  output logic [31:0]         csr_rd_data
);

  typedef struct packed {
    logic [31:0] zbuf_addr;
    logic [31:0] zbuf_pitch;
    logic [31:0] cbuf_addr;
    logic [31:0] cbuf_pitch;
    logic [2:0]  sfunc;
    logic [2:0]  zfunc;
    logic [2:0]  sfail;
    logic [2:0]  zpass;
    logic [2:0]  zfail;
    logic [2:0]  blend_mode_a;
    logic [2:0]  blend_mode_rgb;
    logic [3:0]  dst_a;
    logic [3:0]  dst_rgb;
    logic [3:0]  src_a;
    logic [3:0]  src_rgb;
    logic [31:0] blend_const;
    logic [3:0]  logic_op;
  } rop_csrs_t;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_COPY} st_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  // Bits above each field's width inside its byte lane are dropped.
  function automatic rop_csrs_t f_wr(rop_csrs_t s, logic [3:0] a, logic [31:0] d);
    rop_csrs_t r;
    r = s;
    case (a)
      4'd0: r.zbuf_addr  = d;
      4'd1: r.zbuf_pitch = d;
      4'd2: r.cbuf_addr  = d;
      4'd3: r.cbuf_pitch = d;
      4'd4: begin r.sfunc = d[10:8]; r.zfunc = d[2:0]; end
      4'd5: begin r.sfail = d[18:16]; r.zpass = d[10:8]; r.zfail = d[2:0]; end
      4'd6: begin r.blend_mode_a = d[10:8]; r.blend_mode_rgb = d[2:0]; end
      4'd7: begin
        r.dst_a = d[27:24]; r.dst_rgb = d[19:16];
        r.src_a = d[11:8];  r.src_rgb = d[3:0];
      end
      4'd8: r.blend_const = d;
      4'd9: r.logic_op    = d[3:0];
      default: ;
    endcase
    return r;
  endfunction

  rop_csrs_t           r_shadow [NUM_CTX];
  rop_csrs_t           r_active [NUM_CTX];
  st_t                 r_st     [NUM_CTX];
  st_t                 w_st_nxt [NUM_CTX];
  logic [CNT_BITS-1:0] r_cnt    [NUM_CTX];
  logic [CSR_W-1:0]    r_csrs_out;

  logic [NUM_CTX-1:0]  w_idle, w_fin_ok, w_in_acc, w_dec;
  logic                w_done;
  logic [CTX_BITS-1:0] w_done_ctx;

  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) begin
      w_idle[i]   = (r_st[i] == S_IDLE);
      w_fin_ok[i] = w_idle[i] && (r_cnt[i] != CNT_MAX);
      w_dec[i]    = frag_out && (frag_out_ctx == CTX_BITS'(i)) && (r_cnt[i] != '0);
      // At the ceiling an incoming fragment paired with a retiring one nets
      // to zero, so it is taken rather than letting the count fall to max-1.
      w_in_acc[i] = frag_in && (frag_ctx == CTX_BITS'(i)) && w_idle[i] &&
                    ((r_cnt[i] != CNT_MAX) || w_dec[i]);
    end
  end

  // Lowest-index COPY context is the one reported (and copied) this cycle.
  always_comb begin
    w_done     = 1'b0;
    w_done_ctx = '0;
    for (int i = NUM_CTX - 1; i >= 0; i--) begin
      if (r_st[i] == S_COPY) begin
        w_done     = 1'b1;
        w_done_ctx = CTX_BITS'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) begin
      w_st_nxt[i] = r_st[i];
      case (r_st[i])
        S_IDLE: if (commit_valid && commit_ctx == CTX_BITS'(i))
                  w_st_nxt[i] = (r_cnt[i] == '0 && !w_in_acc[i]) ? S_COPY : S_PEND;
        S_PEND: if (r_cnt[i] == '0) w_st_nxt[i] = S_COPY;
        S_COPY: if (w_done_ctx == CTX_BITS'(i)) w_st_nxt[i] = S_IDLE;
        default: w_st_nxt[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        r_st[i]     <= S_IDLE;
        r_cnt[i]    <= '0;
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_csrs_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        r_st[i] <= w_st_nxt[i];
        if (w_in_acc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_in_acc[i] && w_dec[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
        if (csr_wr_valid && w_idle[i] && csr_wr_ctx == CTX_BITS'(i))
          r_shadow[i] <= f_wr(r_shadow[i], csr_wr_addr, csr_wr_data);
        if (w_done && w_done_ctx == CTX_BITS'(i))
          r_active[i] <= r_shadow[i];
      end
      // Bypass the shadow so a copy shows on csrs_out the cycle after commit_done.
      r_csrs_out <= (w_done && w_done_ctx == sel_ctx) ? r_shadow[sel_ctx] : r_active[sel_ctx];
    end
  end

`ifdef ROP_CSR_READBACK_EN
  logic [31:0] r_rd_data;
  rop_csrs_t   w_rd_s;
  logic [31:0] w_rd_word;

  always_comb begin
    w_rd_s    = r_shadow[csr_rd_ctx];
    w_rd_word = '0;
    case (csr_rd_addr)
      4'd0: w_rd_word = w_rd_s.zbuf_addr;
      4'd1: w_rd_word = w_rd_s.zbuf_pitch;
      4'd2: w_rd_word = w_rd_s.cbuf_addr;
      4'd3: w_rd_word = w_rd_s.cbuf_pitch;
      4'd4: begin w_rd_word[10:8] = w_rd_s.sfunc; w_rd_word[2:0] = w_rd_s.zfunc; end
      4'd5: begin
        w_rd_word[18:16] = w_rd_s.sfail; w_rd_word[10:8] = w_rd_s.zpass;
        w_rd_word[2:0]   = w_rd_s.zfail;
      end
      4'd6: begin
        w_rd_word[10:8] = w_rd_s.blend_mode_a; w_rd_word[2:0] = w_rd_s.blend_mode_rgb;
      end
      4'd7: begin
        w_rd_word[27:24] = w_rd_s.dst_a; w_rd_word[19:16] = w_rd_s.dst_rgb;
        w_rd_word[11:8]  = w_rd_s.src_a; w_rd_word[3:0]   = w_rd_s.src_rgb;
      end
      4'd8: w_rd_word = w_rd_s.blend_const;
      4'd9: w_rd_word[3:0] = w_rd_s.logic_op;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            r_rd_data <= '0;
    else if (csr_rd_valid) r_rd_data <= w_rd_word;
  end

  assign csr_rd_data = r_rd_data;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{csr_rd_valid, csr_rd_ctx, csr_rd_addr};
  assign csr_rd_data = '0;
`endif

  assign csr_wr_ready    = w_idle[csr_wr_ctx];
  assign commit_ready    = w_idle[commit_ctx];
  assign frag_in_ready   = w_fin_ok[frag_ctx];
  assign commit_done     = w_done;
  assign commit_done_ctx = w_done_ctx;
  assign csrs_out        = r_csrs_out;

endmodule

// File: tb/tb_rop_csr_bank.sv
// Directed bench for rop_csr_bank (NUM_CTX=4, CNT_BITS=8).
// Inputs are driven 1ns after each rising edge; outputs are sampled 1ns later.
module tb_rop_csr_bank;
  logic        clk = 0, reset = 0;
  logic        csr_wr_valid = 0, csr_wr_ready;
  logic [1:0]  csr_wr_ctx = 0;
  logic [3:0]  csr_wr_addr = 0;
  logic [31:0] csr_wr_data = 0;
  logic        commit_valid = 0, commit_ready;
  logic [1:0]  commit_ctx = 0;
  logic        commit_done;
  logic [1:0]  commit_done_ctx;
  logic        frag_in = 0, frag_in_ready;
  logic [1:0]  frag_ctx = 0;
  logic        frag_out = 0;
  logic [1:0]  frag_out_ctx = 0;
  logic [1:0]  sel_ctx = 0;
  logic [200:0] csrs_out;
  logic        csr_rd_valid = 0;
  logic [1:0]  csr_rd_ctx = 0;
  logic [3:0]  csr_rd_addr = 0;
  logic [31:0] csr_rd_data;

  int n_chk = 0, n_fail = 0;

  rop_csr_bank dut (
    .clk(clk), .reset(reset),
    .csr_wr_valid(csr_wr_valid), .csr_wr_ready(csr_wr_ready), .csr_wr_ctx(csr_wr_ctx),
    .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_ctx(commit_ctx),
    .commit_done(commit_done), .commit_done_ctx(commit_done_ctx),
    .frag_in(frag_in), .frag_in_ready(frag_in_ready), .frag_ctx(frag_ctx),
    .frag_out(frag_out), .frag_out_ctx(frag_out_ctx),
    .sel_ctx(sel_ctx), .csrs_out(csrs_out),
    .csr_rd_valid(csr_rd_valid), .csr_rd_ctx(csr_rd_ctx), .csr_rd_addr(csr_rd_addr),
    .csr_rd_data(csr_rd_data)
  );

  always #5 clk = ~clk;

  // Advance one cycle and drop all single-cycle requests.
  task automatic tick();
    @(posedge clk); #1;
    csr_wr_valid = 0; commit_valid = 0; frag_in = 0; frag_out = 0; csr_rd_valid = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (csrs_out !== '0) begin n_fail++; $display("FAIL rst_csrs_out: got %h exp 0", csrs_out); end
    n_chk++; if (csr_rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_rd_data: got %h exp 0", csr_rd_data); end
    n_chk++; if (commit_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b exp 0", commit_done); end
    n_chk++; if ({commit_ready, csr_wr_ready, frag_in_ready} !== 3'b111) begin
      n_fail++; $display("FAIL rst_readies: got %b exp 111", {commit_ready, csr_wr_ready, frag_in_ready}); end
    reset = 1;
    tick();
  endtask

  task automatic test_commit_drained();
    csr_wr_valid = 1; csr_wr_ctx = 1; csr_wr_addr = 0; csr_wr_data = 32'h1000_0000;
    #1;
    n_chk++; if (csr_wr_ready !== 1'b1) begin n_fail++; $display("FAIL cd_wr_ready: got %b exp 1", csr_wr_ready); end
    tick();
    commit_valid = 1; commit_ctx = 1; sel_ctx = 1;
    csr_rd_valid = 1; csr_rd_ctx = 1; csr_rd_addr = 0;
    #1;
    n_chk++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL cd_commit_ready: got %b exp 1", commit_ready); end
    tick();
    #1;
    n_chk++; if ({commit_done, commit_done_ctx} !== 3'b1_01) begin
      n_fail++; $display("FAIL cd_done: got %b/%0d exp 1/1", commit_done, commit_done_ctx); end
    n_chk++; if (csrs_out[200:169] !== 32'h0) begin n_fail++; $display("FAIL cd_early_zbuf: got %h exp 0", csrs_out[200:169]); end
    n_chk++; if (csr_wr_ready !== 1'b0) begin n_fail++; $display("FAIL cd_wr_frozen: got %b exp 0", csr_wr_ready); end
`ifdef ROP_CSR_READBACK_EN
    n_chk++; if (csr_rd_data !== 32'h1000_0000) begin n_fail++; $display("FAIL cd_readback: got %h exp 10000000", csr_rd_data); end
`endif
    tick();
    n_chk++; if (commit_done !== 1'b0) begin n_fail++; $display("FAIL cd_done_pulse: got %b exp 0", commit_done); end
    n_chk++; if (csrs_out[200:169] !== 32'h1000_0000) begin
      n_fail++; $display("FAIL cd_zbuf: got %h exp 10000000", csrs_out[200:169]); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 3; i++) begin
      frag_in = 1; frag_ctx = 2; #1;
      n_chk++; if (frag_in_ready !== 1'b1) begin n_fail++; $display("FAIL dr_fin_ready%0d: got %b exp 1", i, frag_in_ready); end
      tick();
    end
    csr_wr_valid = 1; csr_wr_ctx = 2; csr_wr_addr = 8; csr_wr_data = 32'hFF00_FF00;
    tick();
    commit_valid = 1; commit_ctx = 2;
    tick();
    // Pending through all three retirements and the cycle the count reads 0.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin frag_out = 1; frag_out_ctx = 2; end
      #1;
      n_chk++; if ({commit_done, csr_wr_ready, frag_in_ready} !== 3'b000) begin
        n_fail++; $display("FAIL dr_pend%0d: got done/wr/fin %b exp 000", i, {commit_done, csr_wr_ready, frag_in_ready}); end
      tick();
    end
    sel_ctx = 2; #1;
    n_chk++; if ({commit_done, commit_done_ctx} !== 3'b1_10) begin
      n_fail++; $display("FAIL dr_done: got %b/%0d exp 1/2", commit_done, commit_done_ctx); end
    tick();
    n_chk++; if (csrs_out[35:4] !== 32'hFF00_FF00) begin
      n_fail++; $display("FAIL dr_blend_const: got %h exp ff00ff00", csrs_out[35:4]); end
    n_chk++; if (csr_wr_ready !== 1'b1) begin n_fail++; $display("FAIL dr_wr_ready: got %b exp 1", csr_wr_ready); end
  endtask

  task automatic test_multi_done();
    frag_in = 1; frag_ctx = 0; tick();
    commit_valid = 1; commit_ctx = 0; tick();   // ctx0 pending, cnt=1
    frag_out = 1; frag_out_ctx = 0; tick();     // cnt0 -> 0
    commit_valid = 1; commit_ctx = 3; tick();   // ctx3 drained; both COPY next
    commit_ctx = 3; #1;
    n_chk++; if ({commit_done, commit_done_ctx} !== 3'b1_00) begin
      n_fail++; $display("FAIL md_first: got %b/%0d exp 1/0", commit_done, commit_done_ctx); end
    n_chk++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL md_ctx3_busy: got %b exp 0", commit_ready); end
    tick();
    n_chk++; if ({commit_done, commit_done_ctx} !== 3'b1_11) begin
      n_fail++; $display("FAIL md_second: got %b/%0d exp 1/3", commit_done, commit_done_ctx); end
    tick();
    n_chk++; if ({commit_done, commit_ready} !== 2'b01) begin
      n_fail++; $display("FAIL md_idle: got done/ready %b exp 01", {commit_done, commit_ready}); end
  endtask

  task automatic test_cnt_sat();
    frag_ctx = 0;
    frag_out = 1; frag_out_ctx = 0; tick();     // retire at cnt=0: ignored
    n_chk++; if (frag_in_ready !== 1'b1) begin n_fail++; $display("FAIL cs_no_wrap: got %b exp 1", frag_in_ready); end
    for (int i = 0; i < 255; i++) begin
      frag_in = 1;
      if (i == 254) begin
        #1;
        n_chk++; if (frag_in_ready !== 1'b1) begin n_fail++; $display("FAIL cs_ready_254: got %b exp 1", frag_in_ready); end
      end
      tick();
    end
    n_chk++; if (frag_in_ready !== 1'b0) begin n_fail++; $display("FAIL cs_full: got %b exp 0", frag_in_ready); end
    frag_in = 1; frag_out = 1; frag_out_ctx = 0; tick();
    n_chk++; if (frag_in_ready !== 1'b0) begin n_fail++; $display("FAIL cs_net_zero: got %b exp 0", frag_in_ready); end
    frag_out = 1; tick();
    n_chk++; if (frag_in_ready !== 1'b1) begin n_fail++; $display("FAIL cs_dec: got %b exp 1", frag_in_ready); end
  endtask

  task automatic test_readback();
    logic [3:0]  addrs [3] = '{4'd4, 4'd7, 4'd12};
    logic [31:0] exps  [3] = '{32'h0000_0707, 32'h0F0F_0F0F, 32'h0};
    for (int i = 0; i < 3; i++) begin
      csr_wr_valid = 1; csr_wr_ctx = 3; csr_wr_addr = addrs[i]; csr_wr_data = 32'hFFFF_FFFF;
      tick();
      csr_rd_valid = 1; csr_rd_ctx = 3; csr_rd_addr = addrs[i];
      tick();
`ifdef ROP_CSR_READBACK_EN
      n_chk++; if (csr_rd_data !== exps[i]) begin
        n_fail++; $display("FAIL rb_word%0d: got %h exp %h", addrs[i], csr_rd_data, exps[i]); end
`else
      n_chk++; if (csr_rd_data !== 32'h0) begin
        n_fail++; $display("FAIL rb_word%0d: got %h exp 0 (exp %h with readback)", addrs[i], csr_rd_data, exps[i]); end
`endif
    end
  endtask

  task automatic test_reset_mid_commit();
    sel_ctx = 1;
    frag_in = 1; frag_ctx = 1; tick();
    commit_valid = 1; commit_ctx = 1; tick();
    commit_ctx = 1; #1;
    n_chk++; if (commit_ready !== 1'b0) begin n_fail++; $display("FAIL rm_pend: got %b exp 0", commit_ready); end
    #2 reset = 0; #1;
    n_chk++; if ({csrs_out, csr_rd_data, commit_done, commit_done_ctx} !== '0) begin
      n_fail++; $display("FAIL rm_outputs: got csrs %h rd %h done %b exp all 0", csrs_out, csr_rd_data, commit_done); end
    @(posedge clk); #1 reset = 1;
    tick();
    n_chk++; if ({commit_ready, frag_in_ready, csr_wr_ready} !== 3'b111) begin
      n_fail++; $display("FAIL rm_idle: got %b exp 111", {commit_ready, frag_in_ready, csr_wr_ready}); end
    commit_valid = 1; commit_ctx = 1; tick();
    n_chk++; if ({commit_done, commit_done_ctx} !== 3'b1_01) begin
      n_fail++; $display("FAIL rm_recommit: got %b/%0d exp 1/1", commit_done, commit_done_ctx); end
    tick();
  endtask

  initial begin
    test_reset();
    test_commit_drained();
    test_drain();
    test_multi_done();
    test_cnt_sat();
    test_readback();
    test_reset_mid_commit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rop_csr_bank.md
# rop_csr_bank

Multi-context, double-buffered control-register bank for the ROP unit. It holds `NUM_CTX` independent ROP state sets. Each set has a shadow copy written by the CSR path and an active copy consumed by the ROP pipeline. A per-context commit copies shadow to active only once that context's in-flight fragments have drained. It sits between the core CSR interface and the ROP depth/stencil/blend stages.

## Interface
- `NUM_CTX`, 4 — number of contexts; ≥1.
- `CTX_BITS`, `$clog2(NUM_CTX)` (min 1) — context index width.
- `CNT_BITS`, 8 — width of the per-context in-flight fragment counter.
- `clk` in 1 — clock.
- `reset` in 1 — asynchronous, active-low reset.
- `csr_wr_valid` in 1 — shadow write request.
- `csr_wr_ready` out 1 — write accepted.
- `csr_wr_ctx` in CTX_BITS — target context.
- `csr_wr_addr` in 4 — word address 0..9.
- `csr_wr_data` in 32 — write data.
- `commit_valid` in 1 — commit request.
- `commit_ready` out 1 — commit accepted.
- `commit_ctx` in CTX_BITS — context to commit.
- `commit_done` out 1 — one-cycle pulse when the active copy has been updated.
- `commit_done_ctx` out CTX_BITS — context of `commit_done`.
- `frag_in` in 1 — one fragment of `frag_ctx` enters the pipeline.
- `frag_in_ready` out 1 — low when that context's counter is at max or a commit is pending on it.
- `frag_ctx` in CTX_BITS — context of `frag_in`.
- `frag_out` in 1 — one fragment of `frag_out_ctx` retires.
- `frag_out_ctx` in CTX_BITS — context of `frag_out`.
- `sel_ctx` in CTX_BITS — context whose active state is presented.
- `csrs_out` out $bits(rop_csrs_t) — active state of `sel_ctx`, registered.
- `csr_rd_valid` in 1 — shadow readback request.
- `csr_rd_ctx` in CTX_BITS — context to read back.
- `csr_rd_addr` in 4 — word address to read back.
- `csr_rd_data` out 32 — readback data.

## Operation
- Word map (fields right-justified in byte lanes; upper bits of each lane ignored on write and read as 0):
  - 0 zbuf_addr; 1 zbuf_pitch; 2 cbuf_addr; 3 cbuf_pitch.
  - 4 {sfunc[15:8], zfunc[7:0]}.
  - 5 {sfail[23:16], zpass[15:8], zfail[7:0]}.
  - 6 {blend_mode_a[15:8], blend_mode_rgb[7:0]}.
  - 7 {dst_a[31:24], dst_rgb[23:16], src_a[15:8], src_rgb[7:0]}.
  - 8 blend_const; 9 logic_op[7:0].
  - Addresses 10..15: write accepted and dropped; readback returns 0.
- Per-context commit FSM:
  - IDLE → PEND on a commit handshake.
  - PEND → COPY when cnt==0 (same cycle as the handshake if cnt is already 0 and no `frag_in` to that context).
  - COPY: active ← shadow, `commit_done` pulses, → IDLE.
- `commit_ready` = FSM of `commit_ctx` is IDLE.
- `csr_wr_ready` = FSM of `csr_wr_ctx` is not PEND/COPY. Shadow is frozen while its commit is outstanding.
- Fragment counter:
  - +1 on accepted `frag_in`; −1 on `frag_out`.
  - Simultaneous in and out on the same context: net 0.
  - `frag_out` at cnt==0 is ignored; the counter never wraps.
  - `frag_in_ready` = cnt≠max && FSM≠PEND/COPY.
- Several contexts may be in PEND at once. Multiple COPYs completing in one cycle are reported lowest-index-first, one `commit_done` per cycle; the others stay in COPY until reported.
- Reset drives every shadow, active, counter, FSM (IDLE) and output register to 0. Reset mid-commit abandons the commit.

## Timing
- Shadow write: visible to readback the cycle after the handshake.
- Commit with drained context: handshake in cycle N, COPY in N+1, `commit_done` high in N+1, `csrs_out` updated in N+2 if `sel_ctx` matches.
- `csrs_out` and `csr_rd_data` are registered: 1-cycle latency from `sel_ctx`/`csr_rd_*`.
- No combinational path from inputs to outputs except the ready signals.

## Configuration
- `ROP_CSR_READBACK_EN`:
  - Defined: the readback port is live.
  - Undefined: `csr_rd_data` is tied to 0 and the readback mux is removed.
  - Shadow and active behaviour is identical in both builds.

## Test plan
- Write ctx1 word0=0x1000_0000, commit ctx1 with cnt=0, `sel_ctx`=1 → `commit_done` with ctx=1 the next cycle; `csrs_out.zbuf_addr`=0x1000_0000 one cycle later.
- 3×`frag_in` on ctx2, write word8=0xFF00FF00, commit ctx2 → no `commit_done` and `csr_wr_ready`=0 for ctx2 until the 3rd `frag_out`; COPY the following cycle.
- Commit ctx0 and ctx3 both drained, `frag_out` to both same cycle → `commit_done` ctx0, then ctx3 the next cycle.
- Drive `frag_in` 255 times on ctx0 (CNT_BITS=8) → `frag_in_ready`=0; `frag_in`+`frag_out` together → cnt stays 255; `frag_out` at cnt=0 → stays 0.
- Write 0xFFFFFFFF to word4 → readback 0x0000_0707 with 3-bit funcs (readback build); non-readback build → 0.
- Assert `reset` low while ctx1 is in PEND → all outputs 0, FSM IDLE, `commit_ready`=1 after release.
